stage_1_fetch: RTL and testbench

- Pipeline stage 1: generates fetch addresses, runs a req/ack handshake with instruction memory, and buffers returned words in a small FIFO.
- Drives the registered instruction/pc pair consumed by the decode stage.
- Accepts a stall from downstream and a redirect (taken jump/branch) from execute; redirect flushes everything in flight.

---
 rtl/stage_1_fetch_pkg.sv | 13 +
 rtl/stage_1_fetch_fifo.sv | 40 ++++
 rtl/stage_1_fetch.sv | 89 ++++++++
 tb/tb_stage_1_fetch.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/stage_1_fetch_pkg.sv
// stage_1_fetch_pkg: shared types and constants for the fetch stage
package stage_1_fetch_pkg;
  typedef logic Clock;
  typedef logic Bool;
  typedef logic [31:0] Data;
  typedef logic [31:0] Addr;
  localparam Data NOP_INSTRUCTION = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} FetchState;
  typedef struct packed {
    Data instruction;
    Addr pc;
  } FetchEntry;
endpackage

// File: rtl/stage_1_fetch_fifo.sv
// stage_1_fetch_fifo: synchronous fetch buffer with flush taking priority over push
module stage_1_fetch_fifo import stage_1_fetch_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  FetchEntry                wdata,
  output FetchEntry                rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  FetchEntry mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/stage_1_fetch.sv
// stage_1_fetch: fetch address generation, imem req/ack handshake and decode-facing output registers
module stage_1_fetch import stage_1_fetch_pkg::*; #(
  parameter Addr RESET_PC   = 32'h0000_0000,
  parameter int  FIFO_DEPTH = 2,
  parameter Data NOP_INSTR  = NOP_INSTRUCTION
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_enable,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  FetchState state;
  Addr fetch_pc;
  FetchEntry rd_entry, wr_entry;
  logic [CW-1:0] count, count_next;
  logic empty, push, pop, room;
  assign push = state == WAIT && imem_ack && !redirect_enable;
  assign pop = !stall && !empty;
  assign count_next = count + CW'(push) - CW'(pop);
  assign room = count_next < CW'(FIFO_DEPTH);
  assign wr_entry = '{instruction: imem_rdata, pc: imem_addr + 32'd4};
  stage_1_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_enable),
    .wdata(wr_entry),
    .rdata(rd_entry),
    .count(count),
    .empty(empty)
  );
  // an outstanding request is never withdrawn; a redirect mid-request drains its response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect_enable) begin
      fetch_pc <= redirect_addr & ~32'h3;
      if (imem_req && !imem_ack) state <= DRAIN;
      else begin
        state <= IDLE;
        imem_req <= 1'b0;
      end
    end else
      case (state)
        IDLE: if (room) begin
          state <= WAIT;
          imem_req <= 1'b1;
          imem_addr <= fetch_pc;
        end
        WAIT: if (imem_ack) begin
          fetch_pc <= fetch_pc + 32'd4;
          if (room) imem_addr <= imem_addr + 32'd4;
          else begin
            imem_req <= 1'b0;
            state <= IDLE;
          end
        end
        default: if (imem_ack) begin
          imem_req <= 1'b0;
          state <= IDLE;
        end
      endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instruction_out <= NOP_INSTR;
      pc_out <= '0;
      valid_out <= 1'b0;
    end else if (redirect_enable) begin
      instruction_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else if (!stall) begin
      instruction_out <= empty ? NOP_INSTR : rd_entry.instruction;
      pc_out <= empty ? pc_out : rd_entry.pc;
      valid_out <= !empty;
    end
endmodule

// File: tb/tb_stage_1_fetch.sv
// tb_stage_1_fetch: randomized memory/stall/redirect stimulus with a scoreboard of expected fetched words
module tb_stage_1_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect_enable = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_addr = '0, imem_rdata = '0;
  logic imem_req, valid_out;
  logic [31:0] imem_addr, instruction_out, pc_out;
  stage_1_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect_enable(redirect_enable),
    .redirect_addr(redirect_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instruction_out(instruction_out),
    .pc_out(pc_out),
    .valid_out(valid_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0, n_out = 0;
  int min_d = 0, max_d = 0, p_stall = 0, p_redir = 0, wait_cnt = 0, delay = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask
  // instruction memory model with random response delay, plus random stall/redirect
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      wait_cnt = 0;
    end else begin
      stall = $urandom_range(0, 99) < p_stall;
      redirect_enable = $urandom_range(0, 99) < p_redir;
      case ($urandom_range(0, 2))
        0: redirect_addr = $urandom;
        1: redirect_addr = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: redirect_addr = $urandom_range(0, 1023);
      endcase
      if (imem_req && wait_cnt >= delay) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt = 0;
        delay = $urandom_range(min_d, max_d);
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) wait_cnt++;
      end
    end
  end
  logic prev_stall, prev_redir, prev_req, prev_ack, stale, last_valid;
  logic [31:0] prev_addr, exp_pc, last_instr, last_pc;
  int qpre;
  // monitor: each negedge checks the outputs produced by the last edge, then books the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_pc = RST_PC;
      stale = 1'b0;
      prev_stall = 1'b1;
      prev_redir = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_addr = RST_PC;
      qpre = 0;
      last_instr = NOP;
      last_pc = '0;
      last_valid = 1'b0;
    end else begin
      if (prev_redir)
        check("redirect_flush", 128'({valid_out, instruction_out}), 128'({1'b0, NOP}));
      else if (prev_stall)
        check("stall_hold", 128'({valid_out, instruction_out, pc_out}), 128'({last_valid, last_instr, last_pc}));
      else if (qpre > 0) begin
        check("fetch_word", 128'({valid_out, instruction_out, pc_out}), 128'({1'b1, q[0].instr, q[0].pc}));
        void'(q.pop_front());
        n_out++;
      end else
        check("empty_nop", 128'({valid_out, instruction_out, pc_out}), 128'({1'b0, NOP, last_pc}));
      if (prev_req && !prev_ack)
        check("req_hold", 128'({imem_req, imem_addr}), 128'({1'b1, prev_addr}));
      last_valid = valid_out;
      last_instr = instruction_out;
      last_pc = pc_out;
      qpre = q.size();
      if (redirect_enable) begin
        q.delete();
        exp_pc = redirect_addr & ~32'h3;
        if (imem_req) stale = !imem_ack;
      end else if (imem_req && imem_ack) begin
        if (stale) stale = 1'b0;
        else begin
          check("fetch_addr", 128'(imem_addr), 128'(exp_pc));
          q.push_back('{mem_word(imem_addr), imem_addr + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
      end
      prev_stall = stall;
      prev_redir = redirect_enable;
      prev_req = imem_req;
      prev_ack = imem_ack;
      prev_addr = imem_addr;
    end
  end
  initial begin
    int k;
    repeat (3) @(posedge clk);
    #2 check("reset_state", 128'({imem_req, imem_addr, valid_out, instruction_out, pc_out}),
                            128'({1'b0, RST_PC, 1'b0, NOP, 32'h0}));
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(40);
    min_d = 3; max_d = 3;
    run(40);
    min_d = 0; max_d = 0; p_stall = 30;
    run(80);
    max_d = 3; p_stall = 25; p_redir = 8;
    run(1500);
    p_stall = 0; p_redir = 0; min_d = 3;
    k = 0;
    while (!(imem_req && !imem_ack) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("pending_req_seen", 128'(k < 50), 128'(1));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 128'({imem_req, imem_addr, valid_out, instruction_out}), 128'({1'b0, RST_PC, 1'b0, NOP}));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    min_d = 0;
    run(60);
    p_stall = 20; p_redir = 10;
    run(500);
    check("words_delivered", 128'(n_out > 100), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
